// File: rtl/dffram_pkg.sv
// Shared constants, sizing helpers and the response record for the DFFRAM port master.
package dffram_pkg;

  localparam int DFFRAM_DW  = 32;
  localparam int DFFRAM_WEW = 4;

  // Address width of a DFFRAM macro with the given column count.
  function automatic int dffram_aw(input int cols);
    return 8 + $clog2(cols);
  endfunction

  // Number of 32-bit words in a DFFRAM macro with the given column count.
  function automatic int dffram_words(input int cols);
    return 128 * cols;
  endfunction

  typedef struct packed {
    logic [DFFRAM_DW-1:0] rdata;
    logic                 err;
  } dffram_rsp_t;

endpackage

// File: rtl/dffram_rsp_fifo.sv
// Small synchronous response FIFO with occupancy count. Push and pop may
// happen on the same edge; the caller never pushes when full or pops when empty.
module dffram_rsp_fifo
  import dffram_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push,
  input  dffram_rsp_t   din,
  input  logic          pop,
  output dffram_rsp_t   head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dffram_rsp_t   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/dffram_port_master.sv
// Request/response initiator for the DFFRAM single-port macro. Hides the
// macro's one-cycle read timing behind valid/ready channels and buffers
// responses under backpressure (read-before-write data on every request).
// Optional build macro DFFRAM_PORT_BOUNDS_EN: out-of-range addresses are
// answered with rdata=0 and rsp_err=1 without touching the macro.
module dffram_port_master
  import dffram_pkg::*;
#(
  parameter  int COLS      = 1,
  parameter  int RSP_DEPTH = 2,
  localparam int A_WIDTH   = dffram_aw(COLS)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DFFRAM_WEW-1:0] req_we,
  input  logic [A_WIDTH-1:0]    req_addr,
  input  logic [DFFRAM_DW-1:0]  req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DFFRAM_DW-1:0]  rsp_rdata,
`ifdef DFFRAM_PORT_BOUNDS_EN
  output logic                  rsp_err,
`endif
  output logic                  ram_EN,
  output logic [DFFRAM_WEW-1:0] ram_WE,
  output logic [A_WIDTH-1:0]    ram_A,
  output logic [DFFRAM_DW-1:0]  ram_Di,
  input  logic [DFFRAM_DW-1:0]  ram_Do
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic          run_q;
  logic          inflight_q;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occ;
  logic          fifo_empty;
  logic          accept;
  logic          issue;
  logic          oob;
  logic          push;
  logic          pop;
  dffram_rsp_t   fifo_head;
  dffram_rsp_t   bypass;

  // Occupancy counts buffered plus in-flight responses; ready depends on
  // registered state only, so there is no path from rsp_ready.
  assign occ        = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign req_ready  = run_q & (occ < (CW+1)'(RSP_DEPTH));
  assign accept     = req_valid & req_ready;

`ifdef DFFRAM_PORT_BOUNDS_EN
  logic inflight_err_q;

  assign oob    = (req_addr >= A_WIDTH'(dffram_words(COLS)));
  // Out-of-range responses carry zero data regardless of what Do shows.
  assign bypass = '{rdata: (inflight_err_q ? '0 : ram_Do), err: inflight_err_q};

  // Remember whether the in-flight request was refused by the bounds check.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) inflight_err_q <= 1'b0;
    else        inflight_err_q <= accept & oob;
  end
`else
  logic unused_head_err;

  assign oob             = 1'b0;
  assign bypass          = '{rdata: ram_Do, err: 1'b0};
  assign unused_head_err = fifo_head.err;
`endif

  // Macro pins are driven straight from the accepted request.
  assign issue  = accept & ~oob;
  assign ram_EN = issue;
  assign ram_WE = issue ? req_we : '0;
  assign ram_A  = req_addr;
  assign ram_Di = req_wdata;

  // Hold off acceptance until the first edge after reset release, and
  // track the single request whose data appears on ram_Do this cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= accept;
    end
  end

  // Older buffered responses go first; Do is bypassed only when nothing is queued.
  assign fifo_empty = (fifo_count == '0);
  assign rsp_valid  = ~fifo_empty | inflight_q;
  assign pop        = rsp_ready & ~fifo_empty;
  assign push       = inflight_q & ~(rsp_ready & fifo_empty);
  assign rsp_rdata  = fifo_empty ? bypass.rdata : fifo_head.rdata;
`ifdef DFFRAM_PORT_BOUNDS_EN
  assign rsp_err    = fifo_empty ? bypass.err : fifo_head.err;
`endif

  dffram_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push),
    .din   (bypass),
    .pop   (pop),
    .head  (fifo_head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_dffram_port_master.sv
// Bench for dffram_port_master: behavioural DFFRAM macro, word-level
// reference memory feeding an expected-response queue, and a monitor that
// checks every consumed response plus ready/valid/issue rules each cycle.
module tb_dffram_port_master;
  import dffram_pkg::*;

  localparam int COLS      = 1;
  localparam int RSP_DEPTH = 2;
  localparam int AW        = dffram_aw(COLS);
  localparam int WORDS     = dffram_words(COLS);

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          ram_EN;
  logic [3:0]    ram_WE;
  logic [AW-1:0] ram_A;
  logic [31:0]   ram_Di;
  logic [31:0]   ram_Do;
`ifdef DFFRAM_PORT_BOUNDS_EN
  logic          rsp_err;
  logic          last_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_rsp = 0;
  int stall = 0;
  logic        armed;
  logic [31:0] last_rdata;
  logic [32:0] exp_q[$];
  logic [31:0] ram_mem [WORDS];
  logic [31:0] ref_mem [WORDS];

  dffram_port_master #(
    .COLS      (COLS),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
`ifdef DFFRAM_PORT_BOUNDS_EN
    .rsp_err   (rsp_err),
`endif
    .ram_EN    (ram_EN),
    .ram_WE    (ram_WE),
    .ram_A     (ram_A),
    .ram_Di    (ram_Di),
    .ram_Do    (ram_Do)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 ^ (32'h0101_0101 * 32'(i));
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Macro model: Do shows the old word after an EN edge, zero otherwise.
  always @(posedge CLK) begin
    if (ram_EN) begin
      ram_Do <= ram_mem[int'(ram_A)];
      for (int b = 0; b < 4; b++)
        if (ram_WE[b]) ram_mem[int'(ram_A)][8*b +: 8] <= ram_Di[8*b +: 8];
    end else begin
      ram_Do <= '0;
    end
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always @(negedge RST_N) exp_q.delete();

  // Scoreboard input: every accepted request yields its expected response.
  always @(posedge CLK) begin
    if (RST_N && req_valid && req_ready) begin
      int a;
      a = int'(req_addr);
      n_acc++;
      if (a >= WORDS) begin
        exp_q.push_back({32'h0, 1'b1});
      end else begin
        exp_q.push_back({ref_mem[a], 1'b0});
        for (int b = 0; b < 4; b++)
          if (req_we[b]) ref_mem[a][8*b +: 8] = req_wdata[8*b +: 8];
      end
    end
  end

  // Monitor: protocol rules each cycle, and response data on every handshake.
  always @(negedge CLK) begin
    if (RST_N) begin
      logic        exp_en;
      logic [32:0] e;
      if (armed) chk("req_ready", req_ready, exp_q.size() < RSP_DEPTH);
      chk("rsp_valid", rsp_valid, exp_q.size() > 0);
      exp_en = req_valid && req_ready && (int'(req_addr) < WORDS);
      chk("ram_EN", ram_EN, exp_en);
      chk("ram_WE", ram_WE, exp_en ? req_we : 4'b0000);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got rdata %0h expected no response", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e[32:1]);
`ifdef DFFRAM_PORT_BOUNDS_EN
          chk("rsp_err", rsp_err, e[0]);
          last_err = rsp_err;
`endif
        end
        last_rdata = rsp_rdata;
        n_rsp++;
      end
    end
  end

  task automatic send(input logic [3:0] we, input logic [AW-1:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (req_ready) begin
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        return;
      end
      stall++;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: req_ready got 0 expected 1 within 100 cycles");
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) return;
      @(posedge CLK);
      #1;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r0;
    int a0;
    logic acc;
    for (int i = 0; i < WORDS; i++) begin
      ram_mem[i] <= init_word(i);
      ref_mem[i] = init_word(i);
    end
    RST_N = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 4'hF; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ram_EN", ram_EN, 0);
    chk("rst_ram_WE", ram_WE, 0);
    req_valid = 1'b0;
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Write then read back, with single-cycle response latency.
    send(4'hF, AW'(5), 32'hDEADBEEF);
    #3;
    chk("latency_1cyc", rsp_valid, 1);
    send(4'h0, AW'(5), 32'h0);
    drain();
    chk("wr_rd_data", last_rdata, 32'hDEADBEEF);

    // Partial byte-lane write.
    send(4'b0101, AW'(5), 32'h11223344);
    send(4'h0, AW'(5), 32'h0);
    drain();
    chk("byte_lanes", last_rdata, 32'hDE22BE44);

    // Backpressure: only RSP_DEPTH requests accepted while responses stall.
    rsp_ready = 1'b0;
    a0 = n_acc;
    req_valid = 1'b1; req_we = 4'h0; req_addr = AW'(10); req_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      acc = req_ready;
      @(posedge CLK);
      #1;
      if (acc) req_addr = req_addr + 1'b1;
    end
    chk("bp_accepted", n_acc - a0, 2);
    chk("bp_ready_low", req_ready, 0);
    rsp_ready = 1'b1;
    @(negedge CLK);
    chk("bp_ready_before_pop", req_ready, 0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("bp_ready_after_pop", req_ready, 1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    chk("bp_third_accepted", n_acc - a0, 3);
    drain();

    // Streaming reads: one per cycle, responses back to back.
    s0 = stall;
    r0 = n_rsp;
    for (int i = 0; i < 64; i++) send(4'h0, AW'(i), $urandom);
    #6;
    chk("stream_rsp_count", n_rsp - r0, 64);
    chk("stream_stalls", stall - s0, 0);
    @(posedge CLK);
    #1;
    drain();

    // Reset with two responses outstanding.
    rsp_ready = 1'b0;
    send(4'h0, AW'(20), 32'h0);
    send(4'h0, AW'(21), 32'h0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    req_valid = 1'b1;
    #1;
    chk("midrst_ram_EN", ram_EN, 0);
    req_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    rsp_ready = 1'b1;
    send(4'h0, AW'(22), 32'h0);
    drain();
    chk("post_reset_read", last_rdata, init_word(22));

`ifdef DFFRAM_PORT_BOUNDS_EN
    // Out-of-range request is answered but never issued.
    req_valid = 1'b1; req_we = 4'hF; req_addr = AW'(8'h80); req_wdata = 32'hFFFF_FFFF;
    @(negedge CLK);
    chk("oob_ready", req_ready, 1);
    chk("oob_ram_EN", ram_EN, 0);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    drain();
    chk("oob_rdata", last_rdata, 0);
    chk("oob_err", last_err, 1);
    send(4'h0, AW'(8'h7F), 32'h0);
    drain();
    chk("inrange_err", last_err, 0);
`endif

    // Randomised traffic with random response backpressure.
    req_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      acc = req_valid && req_ready;
      @(posedge CLK);
      #1;
      rsp_ready = ($urandom_range(9) < 7);
      if (!req_valid || acc) begin
        req_valid = ($urandom_range(3) != 0);
        req_we    = $urandom_range(1) ? 4'($urandom) : 4'h0;
`ifdef DFFRAM_PORT_BOUNDS_EN
        req_addr  = AW'($urandom_range(255));
`else
        req_addr  = AW'($urandom_range(WORDS - 1));
`endif
        req_wdata = $urandom;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
